// File: rtl/dfmul_pkg.sv
// Shared definitions for the DFMUL mantissa multiplier: one-hot state encoding,
// default widths and working_key bit positions.
package dfmul_pkg;

    localparam int MANT_W_DEF = 53;
    localparam int KEY_W_DEF  = 32;
    localparam int CNT_W      = $clog2(MANT_W_DEF);

    localparam int KEY_SKIP = 0;
    localparam int KEY_EXIT = 1;
    localparam int KEY_BYP  = 2;

    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_ITER = 4'b0010;
    localparam logic [3:0] ST_DONE = 4'b0100;
    localparam logic [3:0] ST_ZERO = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE = ST_IDLE,
        S_ITER = ST_ITER,
        S_DONE = ST_DONE,
        S_ZERO = ST_ZERO
    } state_t;

endpackage

// File: rtl/dfmul_shift_add_dp.sv
// Radix-2 shift-add datapath: multiplicand, multiplier, accumulator and step counter.
// acc_nxt exposes the value the accumulator takes on the coming edge.
module dfmul_shift_add_dp #(
    parameter int MANT_W = 53,
    parameter int CNT_BITS = 6
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  load_s,
    input  logic                  iter_s,
    input  logic                  zero_s,
    input  logic                  skip_s,
    input  logic [MANT_W-1:0]     a,
    input  logic [MANT_W-1:0]     b,
    output logic [2*MANT_W-1:0]   acc_s,
    output logic [2*MANT_W-1:0]   acc_nxt_s,
    output logic [CNT_BITS-1:0]   cnt_s
);

    logic [MANT_W-1:0]   mcand_r, mcand_nxt_s;
    logic [MANT_W-1:0]   mplier_r, mplier_nxt_s;
    logic [2*MANT_W-1:0] acc_r;
    logic [CNT_BITS-1:0] cnt_r, cnt_nxt_s;
    logic [2*MANT_W-1:0] pp_s;

    assign pp_s      = {{MANT_W{1'b0}}, mcand_r} << cnt_r;
    assign acc_s     = acc_r;
    assign cnt_s     = cnt_r;

    // Next-value selection for load, one shift-add step, zero early-out or hold
    always_comb begin
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        cnt_nxt_s    = cnt_r;
        acc_nxt_s    = acc_r;
        if (load_s) begin
            mcand_nxt_s  = a;
            mplier_nxt_s = b;
            cnt_nxt_s    = {CNT_BITS{1'b0}};
            acc_nxt_s    = {(2*MANT_W){1'b0}};
        end else if (iter_s) begin
            if (mplier_r[0] && !skip_s) begin
                acc_nxt_s = acc_r + pp_s;
            end else begin
                acc_nxt_s = acc_r;
            end
            mplier_nxt_s = mplier_r >> 1;
            cnt_nxt_s    = cnt_r + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else if (zero_s) begin
            acc_nxt_s = {(2*MANT_W){1'b0}};
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Datapath registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mcand_r  <= {MANT_W{1'b0}};
            mplier_r <= {MANT_W{1'b0}};
            cnt_r    <= {CNT_BITS{1'b0}};
            acc_r    <= {(2*MANT_W){1'b0}};
        end else begin
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            cnt_r    <= cnt_nxt_s;
            acc_r    <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/dfmul_mant_mul_hs.sv
// ap_ctrl_hs 53x53 mantissa multiplier (shift-add) with key-locked FSM.
// Locking transitions are compiled in only when DFMUL_MANT_KEY_LOCK_EN is defined.
module dfmul_mant_mul_hs
    import dfmul_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int KEY_W  = KEY_W_DEF
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [MANT_W-1:0]   a,
    input  logic [MANT_W-1:0]   b,
    output logic [2*MANT_W-1:0] ap_return,
    input  logic [KEY_W-1:0]    working_key
);

    localparam int CNT_BITS = $clog2(MANT_W);

    state_t              state_r, state_nxt_s;
    logic                load_s, iter_s, zero_s, skip_s;
    logic                key_byp_s, key_exit_s, last_s;
    logic [2*MANT_W-1:0] acc_s, acc_nxt_s, ret_r;
    logic [CNT_BITS-1:0] cnt_s;

`ifdef DFMUL_MANT_KEY_LOCK_EN
    logic unused_key_s;
    assign key_byp_s    = working_key[KEY_BYP] && (a[1:0] == 2'b01);
    assign skip_s       = working_key[KEY_SKIP] && (cnt_s[1:0] == 2'b01);
    assign key_exit_s   = working_key[KEY_EXIT] && (cnt_s[3:2] == 2'b01);
    assign unused_key_s = ^working_key[KEY_W-1:3];
`else
    logic unused_key_s;
    assign key_byp_s    = 1'b0;
    assign skip_s       = 1'b0;
    assign key_exit_s   = 1'b0;
    assign unused_key_s = ^working_key;
`endif

    assign last_s = (cnt_s == CNT_BITS'(MANT_W - 1));

    dfmul_shift_add_dp #(
        .MANT_W   (MANT_W),
        .CNT_BITS (CNT_BITS)
    ) u_dp (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .load_s    (load_s),
        .iter_s    (iter_s),
        .zero_s    (zero_s),
        .skip_s    (skip_s),
        .a         (a),
        .b         (b),
        .acc_s     (acc_s),
        .acc_nxt_s (acc_nxt_s),
        .cnt_s     (cnt_s)
    );

    // FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        iter_s      = 1'b0;
        zero_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (ap_start) begin
                    load_s = 1'b1;
                    if (key_byp_s) begin
                        state_nxt_s = S_DONE;
                    end else if ((a == {MANT_W{1'b0}}) || (b == {MANT_W{1'b0}})) begin
                        state_nxt_s = S_ZERO;
                    end else begin
                        state_nxt_s = S_ITER;
                    end
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_ITER: begin
                iter_s = 1'b1;
                if (last_s || key_exit_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_ITER;
                end
            end
            S_ZERO: begin
                zero_s      = 1'b1;
                state_nxt_s = S_DONE;
            end
            S_DONE: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Result register: captured on entry to S_DONE; the bypass path returns the stale acc
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ret_r <= {(2*MANT_W){1'b0}};
        end else if (state_nxt_s == S_DONE) begin
            ret_r <= (state_r == S_IDLE) ? acc_s : acc_nxt_s;
        end else begin
            ret_r <= ret_r;
        end
    end

    assign ap_return = ret_r;
    assign ap_done   = (state_r == S_DONE);
    assign ap_ready  = ap_rst_n && (state_r == S_IDLE) && ap_start;
    assign ap_idle   = (state_r == S_IDLE) && !ap_start;

endmodule

// File: tb/tb_dfmul_mant_mul_hs.sv
// Self-checking bench for dfmul_mant_mul_hs: transaction-level model plus directed pins.
module tb_dfmul_mant_mul_hs;

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [52:0]   a;
    logic [52:0]   b;
    logic [105:0]  ap_return;
    logic [31:0]   working_key;

    int checks;
    int errors;
    bit chk_en;

    // transaction model state
    bit            m_busy;
    int            m_left;
    logic [105:0]  m_prod;
    logic [105:0]  m_ret;
    bit            exp_ready, exp_idle, exp_done;

    dfmul_mant_mul_hs dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the transaction model
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            m_busy = 1'b0;
            m_left = 0;
            m_ret  = '0;
        end
        if (chk_en) begin
            if (m_busy) m_left--;
            exp_done = m_busy && (m_left == 0);
            if (exp_done) m_ret = m_prod;
            exp_ready = ap_rst_n && ap_start && !m_busy;
            exp_idle  = !m_busy && !ap_start;
            chk("ap_done",   106'(ap_done),  106'(exp_done));
            chk("ap_ready",  106'(ap_ready), 106'(exp_ready));
            chk("ap_idle",   106'(ap_idle),  106'(exp_idle));
            chk("ap_return", ap_return,      m_ret);
            if (exp_done) m_busy = 1'b0;
            if (exp_ready) begin
                m_busy = 1'b1;
                m_left = ((a == 53'd0) || (b == 53'd0)) ? 2 : 54;
                m_prod = {53'd0, a} * {53'd0, b};
            end
        end
    end

    task automatic run_op(input logic [52:0] av, input logic [52:0] bv, input logic [31:0] kv,
                          input bit hold, output int wait_n, output int lat, output logic [105:0] res);
        @(posedge ap_clk); #1;
        a = av; b = bv; working_key = kv; ap_start = 1'b1;
        wait_n = -1; lat = -1; res = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge ap_clk);
            if (ap_ready) begin
                wait_n = n;
                break;
            end
        end
        if (wait_n < 0) begin
            chk("ready_timeout", 106'd0, 106'd1);
            return;
        end
        for (int k = 1; k <= 120; k++) begin
            @(posedge ap_clk); #1;
            if (k == 1 && !hold) ap_start = 1'b0;
            @(negedge ap_clk);
            if (ap_done) begin
                lat = k;
                res = ap_return;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 106'd0, 106'd1);
    endtask

    initial begin
        int           wn, lat;
        logic [105:0] res;
        logic [105:0] e_max, e6;
        logic [52:0]  ra, rb;
        logic [31:0]  rk;
        int           mode;
        bit           hold;

        checks = 0; errors = 0; chk_en = 1'b0;
        ap_rst_n = 1'b0; ap_start = 1'b0; a = '0; b = '0; working_key = '0;
        e_max = {52'hF_FFFF_FFFF_FFFF, 54'd1};
        e6    = (106'd1 << 104) + (106'd14 << 52) + 106'd49;

        // reset state
        #12;
        chk("rst_done",   106'(ap_done),  106'd0);
        chk("rst_ready",  106'(ap_ready), 106'd0);
        chk("rst_idle",   106'(ap_idle),  106'd1);
        chk("rst_return", ap_return,      106'd0);
        @(negedge ap_clk); #2;
        ap_rst_n = 1'b1;
        chk_en = 1'b1;

        // 1: 3*5 with start held
        run_op(53'd3, 53'd5, 32'd0, 1'b1, wn, lat, res);
        chk("t1_lat", 106'(lat), 106'd54);
        chk("t1_ret", res, 106'd15);
        @(posedge ap_clk); #1; ap_start = 1'b0;

        // 2: zero operand early-out
        run_op(53'd0, 53'h1F_FFFF_FFFF_FFFF, 32'd0, 1'b0, wn, lat, res);
        chk("t2_lat", 106'(lat), 106'd2);
        chk("t2_ret", res, 106'd0);

        // 3: max operands, idle afterwards
        run_op(53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF, 32'd0, 1'b0, wn, lat, res);
        chk("t3_lat", 106'(lat), 106'd54);
        chk("t3_ret", res, e_max);
        @(negedge ap_clk);
        chk("t3_idle", 106'(ap_idle), 106'd1);

        // 4: async reset mid-iteration
        @(posedge ap_clk); #1;
        a = 53'd12345; b = 53'd678; ap_start = 1'b1;
        @(negedge ap_clk);
        chk("t4_ready", 106'(ap_ready), 106'd1);
        @(posedge ap_clk); #1; ap_start = 1'b0;
        repeat (19) @(negedge ap_clk);
        #2; ap_rst_n = 1'b0; #1;
        chk("t4_rst_done",   106'(ap_done),  106'd0);
        chk("t4_rst_ready",  106'(ap_ready), 106'd0);
        chk("t4_rst_idle",   106'(ap_idle),  106'd1);
        chk("t4_rst_return", ap_return,      106'd0);
        repeat (3) @(negedge ap_clk);
        #2; ap_rst_n = 1'b1;
        repeat (60) @(negedge ap_clk);
        run_op(53'd1000, 53'd1000, 32'd0, 1'b0, wn, lat, res);
        chk("t4_after", res, 106'd1000000);

        // 5: back-to-back with start held
        run_op(53'd7, 53'd9, 32'd0, 1'b1, wn, lat, res);
        chk("t5_ret0", res, 106'd63);
        run_op(53'd1, 53'd1, 32'd0, 1'b1, wn, lat, res);
        chk("t5_wait1", 106'(wn), 106'd0);
        chk("t5_ret1", res, 106'd1);
        run_op(53'd0, 53'd4, 32'd0, 1'b1, wn, lat, res);
        chk("t5_wait2", 106'(wn), 106'd0);
        chk("t5_lat2", 106'(lat), 106'd2);
        chk("t5_ret2", res, 106'd0);
        @(posedge ap_clk); #1; ap_start = 1'b0;

        // 6: key handling
`ifdef DFMUL_MANT_KEY_LOCK_EN
        run_op(53'h10_0000_0000_0007, 53'h10_0000_0000_0007, 32'd0, 1'b0, wn, lat, res);
        chk("t6_key0", res, e6);
        chk_en = 1'b0;
        run_op(53'h10_0000_0000_0007, 53'h10_0000_0000_0007, 32'd3, 1'b0, wn, lat, res);
        chk("t6_locked", 106'((lat < 54) || (res != e6)), 106'd1);
        @(negedge ap_clk); #2; ap_rst_n = 1'b0;
        @(negedge ap_clk); #2; ap_rst_n = 1'b1;
        chk_en = 1'b1;
`else
        run_op(53'h10_0000_0000_0007, 53'h10_0000_0000_0007, 32'd7, 1'b0, wn, lat, res);
        chk("t6_lat", 106'(lat), 106'd54);
        chk("t6_ret", res, e6);
`endif

        // randomized operations, checked by the per-cycle model
        for (int i = 0; i < 30; i++) begin
            mode = int'($urandom_range(0, 5));
            ra = 53'({$urandom, $urandom}) | 53'h10_0000_0000_0000;
            rb = 53'({$urandom, $urandom}) | 53'h10_0000_0000_0000;
            if (mode == 0) ra = 53'd0;
            if (mode == 1) rb = 53'd0;
            if (mode == 2) begin
                ra = 53'h1F_FFFF_FFFF_FFFF;
                rb = 53'({$urandom, $urandom});
            end
`ifdef DFMUL_MANT_KEY_LOCK_EN
            rk = 32'd0;
`else
            rk = $urandom;
`endif
            hold = 1'($urandom_range(0, 1));
            run_op(ra, rb, rk, hold, wn, lat, res);
            chk("rnd_lat", 106'(lat), ((ra == 53'd0) || (rb == 53'd0)) ? 106'd2 : 106'd54);
        end
        @(posedge ap_clk); #1; ap_start = 1'b0;
        repeat (4) @(negedge ap_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
